// File: rtl/shift_pkg.sv
// Shared constants for the shift arbiter: default widths, op encodings
// and result-stage state encodings.
package shift_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_AMT_W  = 4;

  localparam logic [1:0] OP_SHL  = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_ROR  = 2'b10;
  localparam logic [1:0] OP_PASS = 2'b11;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/shift_core.sv
// Purely combinational shift network: logical left, arithmetic right,
// rotate right and pass-through on a signed DATA_W operand.
module shift_core
  import shift_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int AMT_W  = DEF_AMT_W
) (
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_data,
  input  logic [AMT_W-1:0]  i_amt,
  output logic [DATA_W-1:0] o_result
);

  // NOTE: every output of an always_comb gets a default first so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    o_result = i_data;
    case (i_op)
      OP_SHL:  o_result = i_data << i_amt;
      OP_SHR:  o_result = $signed(i_data) >>> i_amt;
      // Doubling the word turns a rotate into a plain shift of the low half.
      OP_ROR:  o_result = DATA_W'({i_data, i_data} >> i_amt);
      default: o_result = i_data;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift_core between two requesters,
// with a single registered result stage under valid/ready backpressure.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int AMT_W  = DEF_AMT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [AMT_W-1:0]  req0_amt,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [AMT_W-1:0]  req1_amt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic              busy
);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_last_grant;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_id;

  logic                w_accept_ok;
  logic                w_grant0;
  logic                w_grant1;
  logic                w_accept;
  logic [1:0]          w_op;
  logic [DATA_W-1:0]   w_data;
  logic [AMT_W-1:0]    w_amt;
  logic [DATA_W-1:0]   w_result;

  // A result can be taken in whenever the stage is empty or draining this cycle.
  assign w_accept_ok = (r_state == EMPTY) | rsp_ready;

  // Under contention the requester that was not granted last time wins.
  assign w_grant0 = req0_valid & (~req1_valid | r_last_grant);
  assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);

  assign req0_ready = w_accept_ok & w_grant0;
  assign req1_ready = w_accept_ok & w_grant1;
  assign w_accept   = req0_ready | req1_ready;

  assign w_op   = w_grant1 ? req1_op   : req0_op;
  assign w_data = w_grant1 ? req1_data : req0_data;
  assign w_amt  = w_grant1 ? req1_amt  : req0_amt;

  shift_core #(
    .DATA_W (DATA_W),
    .AMT_W  (AMT_W)
  ) u_shift_core (
    .i_op     (w_op),
    .i_data   (w_data),
    .i_amt    (w_amt),
    .o_result (w_result)
  );

  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      w_state_next = FULL;
    end else if ((r_state == FULL) && rsp_ready) begin
      w_state_next = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= EMPTY;
      r_last_grant <= 1'b1;
      r_rsp_data   <= '0;
      r_rsp_id     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_rsp_data   <= w_result;
        r_rsp_id     <= w_grant1;
        r_last_grant <= w_grant1;
      end
    end
  end

  assign rsp_valid = (r_state == FULL);
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = rsp_valid | req0_valid | req1_valid;

endmodule
